ap_cell_io_ctrl: RTL and testbench

//  Stream-side loader/unloader for the AP cell array.

---
 rtl/ap_cell_pkg.sv | 19 +
 rtl/ap_io_out_reg.sv | 35 +++
 rtl/ap_cell_io_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ap_cell_io_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_cell_pkg.sv
// rtl/ap_cell_pkg.sv - shared mode codes, FSM states and width helper for the AP cell I/O path
package ap_cell_pkg;

    localparam logic [2:0] RowxRow  = 3'd1;
    localparam logic [2:0] ColxCol  = 3'd2;
    localparam logic [2:0] COPY_ROW = 3'd3;
    localparam logic [2:0] COPY_COL = 3'd4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t DUMP = 2'd2;
    localparam state_t FIN  = 2'd3;

    function automatic int io_w(input int w, input int d);
        return (w > d) ? w : d;
    endfunction

endpackage

// File: rtl/ap_io_out_reg.sv
// rtl/ap_io_out_reg.sv - dump word holding register with ready backpressure
module ap_io_out_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         can_load
);

    assign can_load = !out_valid || out_ready;

    // out_data is only rewritten on load, so it stays put while stalled or drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ap_cell_io_ctrl.sv
// rtl/ap_cell_io_ctrl.sv - stream loader/unloader for the AP cell array; AP_CELL_IO_PARITY_EN adds parity ports
module ap_cell_io_ctrl
    import ap_cell_pkg::*;
#(
    parameter  int DATA_WIDTH     = 4,
    parameter  int DATA_DEPTH     = 4,
    parameter  int ADDR_WIDTH_CAM = 8,
    localparam int IO_W           = io_w(DATA_WIDTH, DATA_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic                      cmd_dir,
    input  logic [ADDR_WIDTH_CAM-1:0] cmd_base,
    input  logic [ADDR_WIDTH_CAM-1:0] cmd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IO_W-1:0]           in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IO_W-1:0]           out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      cmd_err,
`ifdef AP_CELL_IO_PARITY_EN
    output logic                      out_parity,
    input  logic                      in_parity,
    output logic                      par_err,
`endif
    output logic [2:0]                input_mode,
    output logic [ADDR_WIDTH_CAM-1:0] addr_input_Row,
    output logic [ADDR_WIDTH_CAM-1:0] addr_input_Col,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col,
    output logic [DATA_WIDTH-1:0]     Ip_row,
    output logic [DATA_DEPTH-1:0]     Ip_col,
    output logic                      rstIn,
    input  logic [DATA_WIDTH-1:0]     Q_out_row,
    input  logic [DATA_DEPTH-1:0]     Q_out_col
);

    localparam int AW = ADDR_WIDTH_CAM;

    state_t        state;
    logic          dir_q;
    logic [AW-1:0] idx;
    logic [AW-1:0] rem;
    logic [AW-1:0] dim_cmd;
    logic [AW-1:0] dim_q;
    logic [AW-1:0] eff_len;
    logic [AW-1:0] idx_next;
    logic          beat;
    logic          in_load;
    logic          in_dump;
    logic          dump_load;
    logic          can_load;
    logic [IO_W-1:0] dump_word;

    assign dim_cmd  = cmd_dir ? AW'(DATA_WIDTH) : AW'(DATA_DEPTH);
    assign dim_q    = dir_q ? AW'(DATA_WIDTH) : AW'(DATA_DEPTH);
    assign eff_len  = (cmd_len == '0 || cmd_len > dim_cmd) ? dim_cmd : cmd_len;
    assign idx_next = (idx == dim_q - AW'(1)) ? '0 : idx + AW'(1);

    assign in_load   = (state == LOAD);
    assign in_dump   = (state == DUMP);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign in_ready  = in_load;
    assign beat      = in_valid && in_ready;

    // Array write enable is active-low and tied to the handshake: one write per accepted beat
    assign rstIn = ~beat;

    assign addr_input_Row  = (in_load && !dir_q) ? idx : '0;
    assign addr_input_Col  = (in_load &&  dir_q) ? idx : '0;
    assign Ip_row          = (in_load && !dir_q) ? in_data[DATA_WIDTH-1:0] : '0;
    assign Ip_col          = (in_load &&  dir_q) ? in_data[DATA_DEPTH-1:0] : '0;
    assign addr_output_Row = (in_dump && !dir_q) ? idx : '0;
    assign addr_output_Col = (in_dump &&  dir_q) ? idx : '0;

    assign dump_word = dir_q ? IO_W'(Q_out_col) : IO_W'(Q_out_row);
    assign dump_load = in_dump && can_load && (rem != '0);

    ap_io_out_reg #(
        .W(IO_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (dump_load),
        .load_data (dump_word),
        .load_last (rem == AW'(1)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .can_load  (can_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            idx        <= '0;
            rem        <= '0;
            input_mode <= 3'd0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_base >= dim_cmd) begin
                            cmd_err <= 1'b1;
                        end else begin
                            dir_q      <= cmd_dir;
                            idx        <= cmd_base;
                            rem        <= eff_len;
                            input_mode <= cmd_dir ? ColxCol : RowxRow;
                            state      <= cmd_op ? DUMP : LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        idx <= idx_next;
                        rem <= rem - AW'(1);
                        if (rem == AW'(1))
                            state <= FIN;
                    end
                end
                DUMP: begin
                    if (dump_load) begin
                        idx <= idx_next;
                        rem <= rem - AW'(1);
                    end
                    if (out_valid && out_ready && out_last)
                        state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AP_CELL_IO_PARITY_EN
    logic beat_parity;

    assign out_parity  = ^out_data;
    assign beat_parity = dir_q ? ^in_data[DATA_DEPTH-1:0] : ^in_data[DATA_WIDTH-1:0];

    // Sticky until reset; the faulty word is still written to the array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par_err <= 1'b0;
        else if (beat && (beat_parity != in_parity))
            par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ap_cell_io_ctrl.sv
// tb/tb_ap_cell_io_ctrl.sv - scoreboard bench for ap_cell_io_ctrl with a behavioural 4x4 cell array
module tb_ap_cell_io_ctrl;

    localparam int DW = 4;
    localparam int DD = 4;
    localparam int AW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          cmd_err;
`ifdef AP_CELL_IO_PARITY_EN
    logic          out_parity;
    logic          in_parity = 1'b0;
    logic          par_err;
`endif
    logic [2:0]    input_mode;
    logic [AW-1:0] addr_input_Row;
    logic [AW-1:0] addr_input_Col;
    logic [AW-1:0] addr_output_Row;
    logic [AW-1:0] addr_output_Col;
    logic [DW-1:0] Ip_row;
    logic [DD-1:0] Ip_col;
    logic          rstIn;
    logic [DW-1:0] Q_out_row;
    logic [DD-1:0] Q_out_col;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [DW-1:0] arr     [DD] = '{default: '0};
    logic [DW-1:0] ref_mem [DD] = '{default: '0};
    logic [4:0]    exp_q[$];
    logic          stall_prev = 1'b0;
    logic [IW-1:0] stall_data = '0;
    int            b_idx = 0;

    always #5 clk = ~clk;

    ap_cell_io_ctrl #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH_CAM(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .cmd_err(cmd_err),
`ifdef AP_CELL_IO_PARITY_EN
        .out_parity(out_parity), .in_parity(in_parity), .par_err(par_err),
`endif
        .input_mode(input_mode),
        .addr_input_Row(addr_input_Row), .addr_input_Col(addr_input_Col),
        .addr_output_Row(addr_output_Row), .addr_output_Col(addr_output_Col),
        .Ip_row(Ip_row), .Ip_col(Ip_col), .rstIn(rstIn),
        .Q_out_row(Q_out_row), .Q_out_col(Q_out_col)
    );

    // Behavioural cell array: writes when rstIn is low, combinational reads
    always @(posedge clk) begin
        if (!rstIn) begin
            if (input_mode == 3'd1)
                arr[addr_input_Row[1:0]] <= Ip_row;
            else if (input_mode == 3'd2)
                for (int r = 0; r < DD; r++) arr[r][addr_input_Col[1:0]] <= Ip_col[r];
        end
    end

    always_comb begin
        Q_out_row = arr[addr_output_Row[1:0]];
        Q_out_col = '0;
        for (int r = 0; r < DD; r++) Q_out_col[r] = arr[r][addr_output_Col[1:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dump_data", out_data, e[3:0]);
                    check("dump_last", out_last, e[4]);
`ifdef AP_CELL_IO_PARITY_EN
                    check("out_parity", out_parity, ^e[3:0]);
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (done) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic int eff(input logic [AW-1:0] len);
        return (len == 0 || len > 4) ? 4 : int'(len);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic do_cmd(input logic op, input logic dir, input logic [AW-1:0] base,
                          input logic [AW-1:0] len);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_base = base; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic dir, input logic [3:0] w, input logic good_par);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
`ifdef AP_CELL_IO_PARITY_EN
        in_parity = good_par ? ^w : ~^w;
`endif
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 1, 0);
        @(posedge clk); #1;
        if (dir) for (int r = 0; r < DD; r++) ref_mem[r][b_idx] = w[r];
        else ref_mem[b_idx] = w;
        b_idx = (b_idx + 1) % 4;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic dir, input logic [AW-1:0] base, input logic [AW-1:0] len,
                        input logic [15:0] words);
        do_cmd(1'b0, dir, base, len);
        b_idx = int'(base);
        for (int k = 0; k < eff(len); k++) beat(dir, words[4*k +: 4], 1'b1);
        wait_idle();
    endtask

    task automatic dump(input logic dir, input logic [AW-1:0] base, input logic [AW-1:0] len,
                        input logic [3:0] pat);
        int n;
        int i;
        logic [3:0] w;
        n = eff(len);
        for (int k = 0; k < n; k++) begin
            i = (int'(base) + k) % 4;
            for (int r = 0; r < 4; r++) w[r] = ref_mem[r][i];
            exp_q.push_back({(k == n - 1), dir ? w : ref_mem[i]});
        end
        out_ready = pat[0];
        do_cmd(1'b1, dir, base, len);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (c == 0) check("first_latency", out_valid, 1);
            out_ready = pat[(c + 1) % 4];
            if (exp_q.size() == 0 && !busy) break;
        end
        check("dump_drained", exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        int d0;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rstIn", rstIn, 1);
        check("rst_mode", input_mode, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        d0 = done_cnt;
        load(1'b0, 8'd0, 8'd0, 16'h1F5A);
        check("load_done", done_cnt - d0, 1);
        check("mode_row", input_mode, 3'd1);
        dump(1'b0, 8'd0, 8'd0, 4'b1111);
        check("dump_done", done_cnt - d0, 2);

        dump(1'b1, 8'd0, 8'd0, 4'b1111);
        check("mode_col", input_mode, 3'd2);

        dump(1'b0, 8'd1, 8'd0, 4'b1001);

        load(1'b0, 8'd3, 8'd3, 16'h0321);
        check("row2_unchanged", arr[2], 4'hF);
        check("row3_wrap", arr[3], 4'h1);

        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dir = 1'b0; cmd_base = 8'd4; cmd_len = 8'd1;
        in_valid = 1'b1; in_data = 4'hC;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("err_pulse", cmd_err, 1);
        check("err_cmd_ready", cmd_ready, 1);
        check("err_no_write", rstIn, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("err_one_cycle", cmd_err, 0);
        dump(1'b0, 8'd0, 8'd9, 4'b1111);

        load(1'b1, 8'd2, 8'd1, 16'h0006);
        dump(1'b1, 8'd2, 8'd1, 4'b1111);
        dump(1'b0, 8'd2, 8'd4, 4'b1111);

        do_cmd(1'b0, 1'b0, 8'd0, 8'd0);
        b_idx = 0;
        beat(1'b0, 4'h9, 1'b1);
        beat(1'b0, 4'h9, 1'b1);
        in_valid = 1'b1; in_data = 4'h9;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_rstIn", rstIn, 1);
        check("abort_mode", input_mode, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        dump(1'b0, 8'd0, 8'd0, 4'b1111);

`ifdef AP_CELL_IO_PARITY_EN
        check("par_err_clear", par_err, 0);
        do_cmd(1'b0, 1'b0, 8'd0, 8'd1);
        b_idx = 0;
        beat(1'b0, 4'h7, 1'b0);
        wait_idle();
        check("par_err_set", par_err, 1);
        load(1'b0, 8'd1, 8'd1, 16'h0003);
        check("par_err_sticky", par_err, 1);
        dump(1'b0, 8'd0, 8'd1, 4'b1111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
